disp_scan_ctrl: RTL and testbench

Time-multiplexed display scan controller that sits directly upstream of the team's 3-to-8 one-hot decoder. It steps a 3-bit digit select through the enabled digits at a programmable dwell rate, inserting blanking gaps between digits to prevent ghosting. It also presents the selected digit's segment/data word, so the decoder output (gated by sel_valid) drives the digit enables while seg_data drives the shared segment lines.

---
 rtl/disp_scan_pkg.sv | 13 +
 rtl/rot_prio_pick8.sv | 27 ++
 rtl/disp_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_disp_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_scan_pkg.sv
// Shared constants and state encoding for the display scan controller.
package disp_scan_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEL_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/rot_prio_pick8.sv
// Rotating priority finder: first set mask bit searching start+1 .. start+7 (mod 8), then start.
module rot_prio_pick8
    import disp_scan_pkg::*;
(
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic [SEL_W-1:0]      start,
    output logic [SEL_W-1:0]      idx,
    output logic                  found,
    output logic                  wrapped
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [SEL_W-1:0] cand;
        idx   = start;
        found = 1'b0;
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            cand = start + SEL_W'(k);
            if (mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        wrapped = found && (idx <= start);
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed digit scan: steps sel through enabled digits with a dwell
// of DIV cycles and BLANK blanking cycles between digits.
module disp_scan_ctrl
    import disp_scan_pkg::*;
#(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned BLANK = 2,
    parameter int unsigned DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_DIGITS-1:0]    digit_mask,
    input  logic [NUM_DIGITS*DW-1:0] digit_data,
    output logic [SEL_W-1:0]         sel,
    output logic                     sel_valid,
    output logic [DW-1:0]            seg_data,
    output logic                     frame_done
);

    localparam int unsigned PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW         = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam int unsigned PRE_LAST   = DIV - 1;
    localparam int unsigned BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;
    // With no blanking the scan goes straight from one digit to the next.
    localparam state_t      ENTRY_ST   = (BLANK == 0) ? ST_ACTIVE : ST_BLANK;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_d;
    logic             valid_d;
    logic [DW-1:0]    seg_d;
    logic             fd_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [BW-1:0]    blank_q, blank_d;

    logic [SEL_W-1:0] pick_start;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             pick_wrapped;

    // IDLE exit wants the lowest set bit, which is a search starting after 7.
    assign pick_start = (state_q == ST_IDLE) ? SEL_W'(NUM_DIGITS - 1) : sel;

    rot_prio_pick8 u_pick (
        .mask    (digit_mask),
        .start   (pick_start),
        .idx     (pick_idx),
        .found   (pick_found),
        .wrapped (pick_wrapped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel        <= '0;
            sel_valid  <= 1'b0;
            seg_data   <= '0;
            frame_done <= 1'b0;
            pre_q      <= '0;
            blank_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel        <= sel_d;
            sel_valid  <= valid_d;
            seg_data   <= seg_d;
            frame_done <= fd_d;
            pre_q      <= pre_d;
            blank_q    <= blank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel;
        valid_d = 1'b0;
        seg_d   = '0;
        fd_d    = 1'b0;
        pre_d   = '0;
        blank_d = '0;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        state_d = ENTRY_ST;
                        valid_d = (ENTRY_ST == ST_ACTIVE);
                    end
                end
                ST_BLANK: begin
                    if (blank_q == BW'(BLANK_LAST)) begin
                        state_d = ST_ACTIVE;
                        valid_d = 1'b1;
                    end else begin
                        blank_d = blank_q + BW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (pre_q == PW'(PRE_LAST)) begin
                        // Mask is only sampled here, so a mid-dwell change never shortens a digit.
                        if (!pick_found) begin
                            state_d = ST_IDLE;
                        end else begin
                            sel_d   = pick_idx;
                            fd_d    = pick_wrapped;
                            state_d = ENTRY_ST;
                            valid_d = (ENTRY_ST == ST_ACTIVE);
                        end
                    end else begin
                        valid_d = 1'b1;
                        pre_d   = pre_q + PW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Segment word follows the digit that will be selected after this edge.
        if (valid_d) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_d == SEL_W'(i)) begin
                    seg_d = digit_data[i*DW +: DW];
                end
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: per-cycle reference model feeding a scoreboard queue,
// a table of scan phases, and hand-written corner-case sequences.
module tb_disp_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLANK = 2;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [7:0]    digit_mask;
    logic [63:0]   digit_data;
    logic [2:0]    sel;
    logic          sel_valid;
    logic [7:0]    seg_data;
    logic          frame_done;

    disp_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digit_mask (digit_mask),
        .digit_data (digit_data),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .seg_data   (seg_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       valid;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    typedef struct {
        string      name;
        logic [7:0] mask;
        int         cycles;
        int         exp_fd;
        logic [7:0] exp_seen;
        logic [11:0] exp_order;
    } vec_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state: m_t counts cycles since the digit's blanking began.
    logic       m_on;
    logic [2:0] m_sel;
    int         m_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [2:0] scan_from(input logic [7:0] m, input logic [2:0] s);
        logic [2:0] r;
        logic [2:0] c;
        r = s;
        for (int k = 8; k >= 1; k--) begin
            c = s + 3'(k);
            if (m[c]) r = c;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_on  = 1'b0;
        m_sel = 3'd0;
        m_t   = 0;
    endtask

    // Predict outputs after the coming edge from the inputs currently applied.
    task automatic model_edge();
        exp_t       e;
        logic [2:0] nx;
        e.fd = 1'b0;
        if (!en) begin
            m_on = 1'b0;
            m_t  = 0;
        end else if (!m_on) begin
            if (digit_mask != 8'h00) begin
                m_on  = 1'b1;
                m_sel = scan_from(digit_mask, 3'd7);
                m_t   = 0;
            end
        end else begin
            m_t++;
            if (m_t == BLANK + DIV) begin
                if (digit_mask == 8'h00) begin
                    m_on = 1'b0;
                end else begin
                    nx    = scan_from(digit_mask, m_sel);
                    e.fd  = (nx <= m_sel);
                    m_sel = nx;
                end
                m_t = 0;
            end
        end
        e.valid = m_on && (m_t >= BLANK);
        e.sel   = m_sel;
        e.seg   = e.valid ? digit_data[m_sel*8 +: 8] : 8'h00;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sel", 32'(sel), 32'(e.sel));
            chk("sel_valid", 32'(sel_valid), 32'(e.valid));
            chk("seg_data", 32'(seg_data), 32'(e.seg));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"mask_ff", 8'hFF, 50, 1, 8'hFF, {3'd0, 3'd1, 3'd2, 3'd3}};
        vecs[1] = '{"mask_a4", 8'hA4, 30, 1, 8'hA4, {3'd2, 3'd5, 3'd7, 3'd2}};
        vecs[2] = '{"mask_10", 8'h10, 26, 4, 8'h10, {3'd4, 3'd4, 3'd4, 3'd4}};
        vecs[3] = '{"mask_81", 8'h81, 26, 2, 8'h81, {3'd0, 3'd7, 3'd0, 3'd7}};

        rst_n      = 1'b0;
        en         = 1'b0;
        digit_mask = 8'h00;
        digit_data = 64'h0;
        model_reset();
        #12;
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_valid", 32'(sel_valid), 32'd0);
        chk("reset_seg", 32'(seg_data), 32'd0);
        chk("reset_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table of scan phases, each started from IDLE.
        for (int v = 0; v < 4; v++) begin
            int          fd_cnt;
            logic [7:0]  seen;
            logic        prev_v;
            logic [2:0]  order[$];
            logic [11:0] got_order;
            en = 1'b0;
            steps(2);
            digit_mask = vecs[v].mask;
            digit_data = {$urandom, $urandom};
            en         = 1'b1;
            fd_cnt = 0;
            seen   = 8'h00;
            prev_v = 1'b0;
            order.delete();
            for (int c = 0; c < vecs[v].cycles; c++) begin
                step();
                if (sel_valid) seen[sel] = 1'b1;
                if (sel_valid && !prev_v) order.push_back(sel);
                prev_v = sel_valid;
                if (frame_done) fd_cnt++;
            end
            got_order = 12'hFFF;
            if (order.size() >= 4) got_order = {order[0], order[1], order[2], order[3]};
            chk({vecs[v].name, "_fd_count"}, 32'(fd_cnt), 32'(vecs[v].exp_fd));
            chk({vecs[v].name, "_seen"}, 32'(seen), 32'(vecs[v].exp_seen));
            chk({vecs[v].name, "_order"}, 32'(got_order), 32'(vecs[v].exp_order));
        end

        // Data change mid-dwell shows up one cycle later; single digit wraps every advance.
        en = 1'b0;
        steps(2);
        digit_mask = 8'h01;
        digit_data = 64'h0;
        digit_data[7:0] = 8'h3F;
        en = 1'b1;
        steps(4);
        chk("data_before_change", 32'(seg_data), 32'h3F);
        digit_data[7:0] = 8'h06;
        step();
        chk("data_after_change", 32'(seg_data), 32'h06);
        steps(2);
        chk("blank_seg_zero", 32'(seg_data), 32'h00);
        chk("blank_valid_low", 32'(sel_valid), 32'd0);
        chk("single_digit_fd", 32'(frame_done), 32'd1);

        // Mask cleared mid-dwell on digit 3: dwell completes, then IDLE with sel held.
        en = 1'b0;
        steps(2);
        digit_mask = 8'h08;
        en = 1'b1;
        steps(4);
        chk("d3_active", 32'(sel_valid), 32'd1);
        digit_mask = 8'h00;
        steps(2);
        chk("d3_dwell_kept", 32'(sel_valid), 32'd1);
        step();
        chk("d3_idle_valid", 32'(sel_valid), 32'd0);
        chk("d3_idle_sel", 32'(sel), 32'd3);
        chk("d3_idle_fd", 32'(frame_done), 32'd0);
        steps(2);
        digit_mask = 8'h01;
        steps(3);
        chk("restart_sel", 32'(sel), 32'd0);
        chk("restart_valid", 32'(sel_valid), 32'd1);

        // Asynchronous reset between edges while blanking.
        en = 1'b0;
        steps(2);
        digit_mask = 8'hFC;
        en = 1'b1;
        steps(7);
        chk("pre_rst_blank_sel", 32'(sel), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 32'(sel), 32'd0);
        chk("async_rst_valid", 32'(sel_valid), 32'd0);
        chk("async_rst_seg", 32'(seg_data), 32'd0);
        chk("async_rst_fd", 32'(frame_done), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        steps(3);
        chk("post_rst_restart", 32'(sel), 32'd2);

        // en dropped mid-ACTIVE.
        step();
        chk("pre_en_drop_valid", 32'(sel_valid), 32'd1);
        en = 1'b0;
        step();
        chk("en_drop_valid", 32'(sel_valid), 32'd0);
        chk("en_drop_sel", 32'(sel), 32'd2);
        steps(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
